// File: rtl/count_sequence_checker_pkg.sv
// Package for the count sequence checker.
// Holds the FSM state encoding, the width of the monitored counter, the
// width of the error count, and the shared step-rule helper.
package count_check_pkg;

  localparam int COUNT_W   = 3;
  localparam int ERR_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // A legal step of the upstream down counter: new == prev - 1, wrapping 0 -> 7.
  function automatic logic is_expected_step(input logic [COUNT_W-1:0] prev,
                                            input logic [COUNT_W-1:0] nxt);
    logic [COUNT_W-1:0] dec;
    dec = prev - COUNT_W'(1);
    return (nxt == dec);
  endfunction

endpackage

// File: rtl/count_sequence_checker_if.sv
// Bus between the upstream counter side (master) and the checker (slave).
//   sample, count_in, clear              : master -> checker
//   locked, wrap_pulse, err_pulse, fault,
//   wrap_count, err_count, state         : checker -> master
interface count_seq_if
  import count_check_pkg::*;
#(
  parameter int WRAP_W = 8
) ();

  logic                 sample;
  logic [COUNT_W-1:0]   count_in;
  logic                 clear;
  logic                 locked;
  logic                 wrap_pulse;
  logic                 err_pulse;
  logic                 fault;
  logic [WRAP_W-1:0]    wrap_count;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           state;

  modport master (
    output sample, count_in, clear,
    input  locked, wrap_pulse, err_pulse, fault, wrap_count, err_count, state
  );

  modport slave (
    input  sample, count_in, clear,
    output locked, wrap_pulse, err_pulse, fault, wrap_count, err_count, state
  );

endinterface

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up counter.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr      : synchronous clear, takes priority over inc
//   inc      : add one unless already all ones
//   count    : registered count value
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Count sequence checker: watches samples from a 3-bit down counter, locks
// onto the sequence, counts wraps (0 -> 7) and mis-steps, and latches a
// fault after ERR_LIMIT consecutive mis-steps while locked.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : count_seq_if slave (sample/count_in/clear in, status out)
// All outputs are registered; a sample's effect is visible the cycle after
// the edge that accepted it.
module count_sequence_checker
  import count_check_pkg::*;
#(
  parameter int ERR_LIMIT = 3,
  parameter int WRAP_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  count_seq_if.slave  bus
);

  localparam logic [2:0] ERR_LIMIT_C = 3'(ERR_LIMIT);

  state_e             state_q,      state_d;
  logic [COUNT_W-1:0] prev_q,       prev_d;
  logic [2:0]         miss_q,       miss_d;
  logic [WRAP_W-1:0]  wrap_cnt_q,   wrap_cnt_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic               err_pulse_q,  err_pulse_d;
  logic               locked_q,     locked_d;
  logic               fault_q,      fault_d;
  logic               err_inc;
  logic [2:0]         miss_inc;
  logic               step_ok;

  assign step_ok  = is_expected_step(prev_q, bus.count_in);
  assign miss_inc = miss_q + 3'(1);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    miss_d       = miss_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_inc      = 1'b0;

    // clear wins over a coincident sample; the sample is dropped entirely.
    if (bus.clear) begin
      state_d    = ST_IDLE;
      miss_d     = '0;
      wrap_cnt_d = '0;
    end else if (bus.sample) begin
      unique case (state_q)
        ST_IDLE: begin
          prev_d  = bus.count_in;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          prev_d = bus.count_in;
          if (step_ok) state_d = ST_TRACK;
        end
        ST_TRACK: begin
          prev_d = bus.count_in;
          if (step_ok) begin
            miss_d = '0;
            if (prev_q == '0) begin
              wrap_pulse_d = 1'b1;
              wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
            end
          end else if (bus.count_in == '1) begin
            // Jump to 7 from a non-zero value is an upstream reload: resync
            // quietly. The run of consecutive misses is broken here.
            state_d = ST_SYNC;
            miss_d  = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_inc;
            if (miss_inc >= ERR_LIMIT_C) state_d = ST_FAULT;
          end
        end
        default: ;  // FAULT ignores samples until clear or rst
      endcase
    end

    locked_d = (state_d == ST_TRACK);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      miss_q       <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      miss_q       <= miss_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_pulse_q  <= err_pulse_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .inc   (err_inc),
    .count (bus.err_count)
  );

  assign bus.state      = state_q;
  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_count = wrap_cnt_q;

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 The block SHALL have parameter ERR_LIMIT, default 3: consecutive mis-steps in TRACK that force FAULT; legal range 1..7.
REQ-002 The block SHALL have parameter WRAP_W, default 8: width of wrap_count.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sample, input, 1 bit: count_in is valid this cycle.
REQ-006 The block SHALL have port count_in, input, 3 bits: value from the upstream 3-bit down counter.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear of state, counts and fault.
REQ-008 The block SHALL have port locked, output, 1 bit: high while in TRACK.
REQ-009 The block SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse on a 000->111 step seen in TRACK.
REQ-010 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse on a mis-step seen in TRACK.
REQ-011 The block SHALL have port fault, output, 1 bit: high while in FAULT.
REQ-012 The block SHALL have port wrap_count, output, WRAP_W bits: wraps seen, modulo 2^WRAP_W.
REQ-013 The block SHALL have port err_count, output, 4 bits: mis-steps seen, saturating at 15.
REQ-014 The block SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-015 The block SHALL define an expected step as new == (prev - 1) mod 8, where prev is the last accepted count_in (3-bit wrap arithmetic).
REQ-016 The block SHALL implement FSM states IDLE=0, SYNC=1, TRACK=2, FAULT=3.
REQ-017 In IDLE, on sample, the block SHALL store count_in as prev and go to SYNC.
REQ-018 In SYNC, on sample, the block SHALL go to TRACK if the step is expected; otherwise it SHALL stay in SYNC; in both cases it SHALL store count_in, with no error counted.
REQ-019 In TRACK, on an expected step, the block SHALL stay in TRACK, clear the miss counter, and pulse wrap_pulse and increment wrap_count when prev==0 and new==7.
REQ-020 In TRACK, when new==7 and prev!=0 (upstream reload/reset), the block SHALL go to SYNC with no error and no wrap.
REQ-021 In TRACK, on any other non-expected step (including new==prev), the block SHALL pulse err_pulse, increment err_count (saturating) and increment the miss counter.
REQ-022 The block SHALL go to FAULT when the miss counter reaches ERR_LIMIT; otherwise it SHALL stay in TRACK.
REQ-023 The block SHALL update prev on every accepted sample in IDLE, SYNC and TRACK.
REQ-024 In FAULT, the block SHALL ignore sample and leave only on clear or rst.
REQ-025 All outputs SHALL be registered; responses SHALL appear in the cycle after the sample edge (latency 1).
REQ-026 Pulses SHALL last exactly one cycle per accepted sample.
REQ-027 Cycles without sample SHALL leave all state unchanged.
REQ-028 clear SHALL, in any state, force IDLE and zero wrap_count, err_count and the miss counter.
REQ-029 When clear and sample are both high in a cycle, clear SHALL win and the sample SHALL be discarded.
REQ-030 locked SHALL be 1 only in TRACK; fault SHALL be 1 only in FAULT.

Reset
REQ-031 rst high SHALL immediately force IDLE and set all outputs to 0: locked, wrap_pulse, err_pulse, fault, wrap_count, err_count, state.
REQ-032 rst high SHALL set prev and the miss counter to 0.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight sample, and no pulse SHALL follow deassertion.

Structure
REQ-034 Package count_check_pkg SHALL hold the state encoding constants, COUNT_W=3, and ERR_CNT_W=4.
REQ-035 One sub-module, sat_counter (parameterised width, inc, clr, saturates at all-ones), SHALL implement err_count.
REQ-036 The FSM, prev register, miss counter and wrap counter SHALL live in the top module.

Verification
REQ-037 Verification SHALL cover: samples 7,6,5 after reset -> state IDLE->SYNC->TRACK, locked=1 after sample 6.
REQ-038 Verification SHALL cover: in TRACK, samples ...,1,0,7,6 -> single wrap_pulse after 7; wrap_count=1; err_count=0.
REQ-039 Verification SHALL cover: in TRACK at prev=4, samples 4,2,2 with ERR_LIMIT=3 -> three err_pulses, err_count=3, FAULT, fault=1, locked=0.
REQ-040 Verification SHALL cover: in TRACK at prev=3, sample 7 -> state SYNC, no err_pulse, no wrap_pulse; then 6 -> TRACK.
REQ-041 Verification SHALL cover: in FAULT, sample and clear in the same cycle -> IDLE, counts 0, sample not stored; next samples 5,4 -> TRACK.
REQ-042 Verification SHALL cover: rst pulsed asynchronously between edges while in TRACK -> outputs 0 immediately; 20 mis-steps later -> err_count holds at 15.
